skills_word_decoder: RTL
========================

SKILLS_WORD_DECODER -- requirements
Module: skills_word_decoder

Interface
REQ-001 Parameter: HIGH_THRESH, default 3'd6, coffee level at or above which coffee_high is asserted.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  packed 32-bit experience word present on in_word.
REQ-005 in_word  input  32  packed word: [31:30] hw, [29:25] sw, [24:21] comm, [20:18] tools, [17:14] ana, [13:9] misc, [8:6] coffee, [5:3] procrast, [2:0] sleep.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 out_valid  output  1  decoded result available.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 skill_count  output  5  number of set bits in in_word[31:9], range 0..23.
REQ-010 hw_cnt 2, sw_cnt 3, comm_cnt 3, tools_cnt 2, ana_cnt 3, misc_cnt 3  outputs  per-group set-bit counts.
REQ-011 coffee, procrast, sleep  output  3 each  copies of in_word[8:6], [5:3], [2:0].
REQ-012 coffee_high  output  1  coffee >= HIGH_THRESH.
REQ-013 busy  output  1  high in SCAN and DONE.

Function
REQ-014 FSM states: IDLE, SCAN, DONE.
REQ-015 in_ready shall be 1 only in IDLE; out_valid shall be 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready, capture in_word into an internal register, clear internal accumulators, load bit index 31, go to SCAN.
REQ-017 SCAN: each cycle examine captured bit[index]; if 1, increment total accumulator and the accumulator of the group owning that index; decrement index.
REQ-018 SCAN shall process exactly indices 31 down to 9 (23 cycles); after index 9 is processed, go to DONE.
REQ-019 Latency: out_valid shall rise exactly 23 clock edges after the accepting edge, independent of word content.
REQ-020 On entry to DONE, all result outputs (counts, coffee/procrast/sleep, coffee_high) shall update simultaneously from the accumulators and captured word.
REQ-021 Result outputs shall hold their values from DONE entry until the next DONE entry, including through IDLE and SCAN.
REQ-022 DONE: on out_ready, go to IDLE; in_ready shall be high the following cycle (no same-cycle accept from DONE).
REQ-023 DONE with out_ready low shall hold state and outputs indefinitely.
REQ-024 in_valid outside IDLE shall be ignored; in_word changes after capture shall not affect the result.
REQ-025 Accumulators shall not wrap: widths are sized for their maximums (23, 2, 5, 4, 3, 4, 5).
REQ-026 coffee_high shall be an unsigned 3-bit compare against HIGH_THRESH; HIGH_THRESH=0 makes it always 1.

Reset
REQ-027 rst high shall immediately force IDLE, in_ready=1, out_valid=0, busy=0, all counts and field outputs 0, coffee_high=0, index 31.
REQ-028 rst asserted mid-SCAN or in DONE shall discard the in-flight word; no out_valid shall follow for it.

Verification
REQ-029 Accept 0x7FFFFF61 -> after 23 edges out_valid=1; skill_count=22, hw=1, sw=5, comm=4, tools=3, ana=4, misc=5, coffee=5, procrast=4, sleep=1, coffee_high=0.
REQ-030 Accept 0x0E063FDF -> skill_count=10, hw=0, sw=3, comm=0, tools=1, ana=1, misc=5, coffee=7, procrast=3, sleep=7, coffee_high=1.
REQ-031 Accept 0xFFFFFFFF then 0x00000000 back-to-back -> first result count=23/all groups max; second count=0, still exactly 23-edge latency; in_ready low throughout each scan.
REQ-032 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_word -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-033 Assert rst at scan cycle 10, release, accept 0x0E063FDF -> no result for the aborted word; new result matches REQ-030.

Source files
------------

// File: rtl/skills_word_decoder_if.sv
// Handshake and result bundle for skills_word_decoder.
// The producer/consumer side uses master; the decoder uses slave.
interface skills_word_decoder_if;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  skill_count;
  logic [1:0]  hw_cnt;
  logic [2:0]  sw_cnt;
  logic [2:0]  comm_cnt;
  logic [1:0]  tools_cnt;
  logic [2:0]  ana_cnt;
  logic [2:0]  misc_cnt;
  logic [2:0]  coffee;
  logic [2:0]  procrast;
  logic [2:0]  sleep;
  logic        coffee_high;
  logic        busy;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, skill_count, hw_cnt, sw_cnt, comm_cnt,
           tools_cnt, ana_cnt, misc_cnt, coffee, procrast, sleep,
           coffee_high, busy
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, skill_count, hw_cnt, sw_cnt, comm_cnt,
           tools_cnt, ana_cnt, misc_cnt, coffee, procrast, sleep,
           coffee_high, busy
  );
endinterface

// File: rtl/skills_word_decoder.sv
// Bit-serial decoder for a packed experience word: scans bits 31..9 one per
// cycle, counting set bits overall and per skill group, then presents results.
module skills_word_decoder #(
  parameter logic [2:0] HIGH_THRESH = 3'd6
) (
  input logic                 clk,
  input logic                 rst,
  skills_word_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'd31;
  localparam logic [4:0] LAST_IDX  = 5'd9;

  localparam logic [2:0] G_HW    = 3'd0;
  localparam logic [2:0] G_SW    = 3'd1;
  localparam logic [2:0] G_COMM  = 3'd2;
  localparam logic [2:0] G_TOOLS = 3'd3;
  localparam logic [2:0] G_ANA   = 3'd4;
  localparam logic [2:0] G_MISC  = 3'd5;

  // Maps a scanned bit index onto the skill group that owns it.
  function automatic logic [2:0] group_of(input logic [4:0] idx);
    logic [2:0] g;
    if (idx >= 5'd30)      g = G_HW;
    else if (idx >= 5'd25) g = G_SW;
    else if (idx >= 5'd21) g = G_COMM;
    else if (idx >= 5'd18) g = G_TOOLS;
    else if (idx >= 5'd14) g = G_ANA;
    else                   g = G_MISC;
    return g;
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [31:0] word_r;
  logic [4:0]  index_r;
  logic [4:0]  total_r, total_nx_s;
  logic [1:0]  hw_r, hw_nx_s;
  logic [2:0]  sw_r, sw_nx_s;
  logic [2:0]  comm_r, comm_nx_s;
  logic [1:0]  tools_r, tools_nx_s;
  logic [2:0]  ana_r, ana_nx_s;
  logic [2:0]  misc_r, misc_nx_s;

  logic [4:0]  skill_count_r;
  logic [1:0]  hw_cnt_r;
  logic [2:0]  sw_cnt_r;
  logic [2:0]  comm_cnt_r;
  logic [1:0]  tools_cnt_r;
  logic [2:0]  ana_cnt_r;
  logic [2:0]  misc_cnt_r;
  logic [2:0]  coffee_r;
  logic [2:0]  procrast_r;
  logic [2:0]  sleep_r;
  logic        coffee_high_r;

  logic        in_ready_s;
  logic        out_valid_s;
  logic        busy_s;
  logic        bit_s;
  logic        accept_s;
  logic        scan_last_s;

  assign bit_s       = word_r[index_r];
  assign accept_s    = (state_r == IDLE) && bus.in_valid;
  assign scan_last_s = (state_r == SCAN) && (index_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state logic: SCAN always lasts exactly 23 cycles regardless of content.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nx_s = SCAN;
        else              state_nx_s = IDLE;
      end
      SCAN: begin
        if (index_r == LAST_IDX) state_nx_s = DONE;
        else                     state_nx_s = SCAN;
      end
      DONE: begin
        if (bus.out_ready) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Handshake and status decode of the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE: in_ready_s = 1'b1;
      SCAN: busy_s     = 1'b1;
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Accumulator increments for the bit under the scan index.
  always_comb begin
    total_nx_s = total_r;
    hw_nx_s    = hw_r;
    sw_nx_s    = sw_r;
    comm_nx_s  = comm_r;
    tools_nx_s = tools_r;
    ana_nx_s   = ana_r;
    misc_nx_s  = misc_r;
    if ((state_r == SCAN) && bit_s) begin
      total_nx_s = total_r + 5'd1;
      case (group_of(index_r))
        G_HW:    hw_nx_s    = hw_r + 2'd1;
        G_SW:    sw_nx_s    = sw_r + 3'd1;
        G_COMM:  comm_nx_s  = comm_r + 3'd1;
        G_TOOLS: tools_nx_s = tools_r + 2'd1;
        G_ANA:   ana_nx_s   = ana_r + 3'd1;
        G_MISC:  misc_nx_s  = misc_r + 3'd1;
        default: misc_nx_s  = misc_r;
      endcase
    end else begin
      total_nx_s = total_r;
    end
  end

  // Capture, scan index and accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r  <= 32'd0;
      index_r <= FIRST_IDX;
      total_r <= 5'd0;
      hw_r    <= 2'd0;
      sw_r    <= 3'd0;
      comm_r  <= 3'd0;
      tools_r <= 2'd0;
      ana_r   <= 3'd0;
      misc_r  <= 3'd0;
    end else if (accept_s) begin
      word_r  <= bus.in_word;
      index_r <= FIRST_IDX;
      total_r <= 5'd0;
      hw_r    <= 2'd0;
      sw_r    <= 3'd0;
      comm_r  <= 3'd0;
      tools_r <= 2'd0;
      ana_r   <= 3'd0;
      misc_r  <= 3'd0;
    end else if (state_r == SCAN) begin
      index_r <= index_r - 5'd1;
      total_r <= total_nx_s;
      hw_r    <= hw_nx_s;
      sw_r    <= sw_nx_s;
      comm_r  <= comm_nx_s;
      tools_r <= tools_nx_s;
      ana_r   <= ana_nx_s;
      misc_r  <= misc_nx_s;
    end
  end

  // Result registers: loaded once on DONE entry (including bit 9), held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skill_count_r <= 5'd0;
      hw_cnt_r      <= 2'd0;
      sw_cnt_r      <= 3'd0;
      comm_cnt_r    <= 3'd0;
      tools_cnt_r   <= 2'd0;
      ana_cnt_r     <= 3'd0;
      misc_cnt_r    <= 3'd0;
      coffee_r      <= 3'd0;
      procrast_r    <= 3'd0;
      sleep_r       <= 3'd0;
      coffee_high_r <= 1'b0;
    end else if (scan_last_s) begin
      skill_count_r <= total_nx_s;
      hw_cnt_r      <= hw_nx_s;
      sw_cnt_r      <= sw_nx_s;
      comm_cnt_r    <= comm_nx_s;
      tools_cnt_r   <= tools_nx_s;
      ana_cnt_r     <= ana_nx_s;
      misc_cnt_r    <= misc_nx_s;
      coffee_r      <= word_r[8:6];
      procrast_r    <= word_r[5:3];
      sleep_r       <= word_r[2:0];
      coffee_high_r <= (word_r[8:6] >= HIGH_THRESH);
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.busy        = busy_s;
  assign bus.skill_count = skill_count_r;
  assign bus.hw_cnt      = hw_cnt_r;
  assign bus.sw_cnt      = sw_cnt_r;
  assign bus.comm_cnt    = comm_cnt_r;
  assign bus.tools_cnt   = tools_cnt_r;
  assign bus.ana_cnt     = ana_cnt_r;
  assign bus.misc_cnt    = misc_cnt_r;
  assign bus.coffee      = coffee_r;
  assign bus.procrast    = procrast_r;
  assign bus.sleep       = sleep_r;
  assign bus.coffee_high = coffee_high_r;

endmodule
